// File: rtl/wide_add_seq_pkg.sv
// Shared constants for the chunked wide adder: chunk width, FSM encoding,
// and the signed-overflow helper.
package wide_add_seq_pkg;

   localparam int unsigned CHUNK_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Carry into the MSB is recovered as s^a^b, so overflow is cout xor that.
   function automatic logic ovf_bit(input logic cout, input logic s_msb,
                                    input logic a_msb, input logic b_msb);
      return cout ^ (s_msb ^ a_msb ^ b_msb);
   endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq; master is the client side.
interface wide_add_seq_if
   import wide_add_seq_pkg::*;
#(
   parameter int unsigned WORDS = 4
);
   localparam int unsigned OP_W = CHUNK_W * WORDS;

   logic            InValid;
   logic            InReady;
   logic [OP_W-1:0] A;
   logic [OP_W-1:0] B;
   logic            Cin;
   logic            Sub;
   logic            OutValid;
   logic            OutReady;
   logic [OP_W-1:0] S;
   logic            Cout;
   logic            Ovf;

   modport master (
      output InValid, A, B, Cin, Sub, OutReady,
      input  InReady, OutValid, S, Cout, Ovf
   );

   modport slave (
      input  InValid, A, B, Cin, Sub, OutReady,
      output InReady, OutValid, S, Cout, Ovf
   );

endinterface

// File: rtl/wide_add_seq_bk16.sv
// 16-bit Brent-Kung parallel-prefix adder, purely combinational.
module BrentKung16 (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] S,
   output logic        Cout
);

   logic [15:0] p;
   logic [15:0] gg;
   logic [15:0] pp;

   // Cin is folded into bit 0 so gg[i] ends up as the carry out of bit i.
   always_comb begin
      p  = A ^ B;
      gg = A & B;
      pp = p;
      gg[0] = gg[0] | (p[0] & Cin);
      for (int unsigned l = 0; l < 4; l++) begin
         for (int unsigned i = 0; i < 16; i++) begin
            if (((i + 1) % (2 << l)) == 0) begin
               gg[i] = gg[i] | (pp[i] & gg[4'(i - (1 << l))]);
               pp[i] = pp[i] & pp[4'(i - (1 << l))];
            end
         end
      end
      for (int l = 2; l >= 0; l--) begin
         for (int unsigned i = 0; i < 16; i++) begin
            if ((i + 1) >= (3 << l) && (((i + 1) - (3 << l)) % (2 << l)) == 0) begin
               gg[i] = gg[i] | (pp[i] & gg[4'(i - (1 << l))]);
               pp[i] = pp[i] & pp[4'(i - (1 << l))];
            end
         end
      end
      S    = p ^ {gg[14:0], Cin};
      Cout = gg[15];
   end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle WORDS*16-bit add/subtract: one 16-bit chunk per cycle, LSB first,
// carry chained through a register around a single BrentKung16.
module wide_add_seq
   import wide_add_seq_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   wide_add_seq_if.slave  bus
);

   localparam int unsigned      IDX_W    = $clog2(WORDS);
   localparam int unsigned      OP_W     = CHUNK_W * WORDS;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

   logic [1:0]                      state_q, state_d;
   logic [WORDS-1:0][CHUNK_W-1:0]   a_q, a_d;
   logic [WORDS-1:0][CHUNK_W-1:0]   b_q, b_d;
   logic [WORDS-1:0][CHUNK_W-1:0]   s_q, s_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic                            carry_q, carry_d;
   logic                            cout_q, cout_d;
   logic                            ovf_q, ovf_d;
   logic                            in_ready_q, in_ready_d;
   logic                            out_valid_q, out_valid_d;

   logic [CHUNK_W-1:0]              bk_a, bk_b, bk_s;
   logic                            bk_cout;
   logic                            last_chunk;

   assign bk_a       = a_q[idx_q];
   assign bk_b       = b_q[idx_q];
   assign last_chunk = (idx_q == IDX_LAST);

   BrentKung16 u_bk16 (
      .A    (bk_a),
      .B    (bk_b),
      .Cin  (carry_q),
      .S    (bk_s),
      .Cout (bk_cout)
   );

   // State and datapath registers; reset wins over everything on the same edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.InValid)  state_d = ST_BUSY;
         ST_BUSY: if (last_chunk)   state_d = ST_DONE;
         ST_DONE: if (bus.OutReady) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // Handshake flags follow the next state so they come straight from flops.
   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      s_d         = s_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      unique case (state_q)
         ST_IDLE: begin
            if (bus.InValid) begin
               a_d     = bus.A;
               b_d     = bus.B ^ {OP_W{bus.Sub}};
               carry_d = bus.Cin ^ bus.Sub;
               idx_d   = '0;
            end
         end
         ST_BUSY: begin
            s_d[idx_q] = bk_s;
            carry_d    = bk_cout;
            if (last_chunk) begin
               idx_d  = '0;
               cout_d = bk_cout;
               ovf_d  = ovf_bit(bk_cout, bk_s[CHUNK_W-1], bk_a[CHUNK_W-1],
                                bk_b[CHUNK_W-1]);
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.InReady  = in_ready_q;
   assign bus.OutValid = out_valid_q;
   assign bus.S        = s_q;
   assign bus.Cout     = cout_q;
   assign bus.Ovf      = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and reference-model checks for wide_add_seq with WORDS=4.
module tb_wide_add_seq;

   localparam int unsigned WORDS = 4;
   localparam int          LAT   = 5;

   logic Clk = 1'b0;
   logic Reset;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   always #5 Clk = ~Clk;

   wide_add_seq_if #(.WORDS(WORDS)) bus ();

   wide_add_seq #(.WORDS(WORDS)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   // Present an operand pair at a negedge; lat = negedges from accept to OutValid, -1 on timeout.
   task automatic send(input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, output int lat);
      int n;
      bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.InValid = 1'b1;
      n = 0;
      while (bus.InReady !== 1'b1 && n < 20) begin
         @(negedge Clk); n++;
      end
      if (bus.InReady !== 1'b1) begin
         bus.InValid = 1'b0; lat = -1;
         return;
      end
      @(negedge Clk);
      bus.InValid = 1'b0;
      lat = 1;
      while (bus.OutValid !== 1'b1 && lat < 30) begin
         @(negedge Clk); lat++;
      end
      if (bus.OutValid !== 1'b1) lat = -1;
   endtask

   task automatic take_result();
      bus.OutReady = 1'b1;
      @(negedge Clk);
      bus.OutReady = 1'b0;
   endtask

   task automatic test_reset();
      bus.InValid = 1'b1; bus.A = 64'h1; bus.B = 64'h1;
      repeat (2) @(negedge Clk);
      total_cnt++;
      if ({bus.InReady, bus.OutValid} !== 2'b10)
         $display("FAIL reset_hs: got %b want 10", {bus.InReady, bus.OutValid});
      else pass_cnt++;
      total_cnt++;
      if ({bus.Cout, bus.Ovf, bus.S} !== 66'h0)
         $display("FAIL reset_out: got %h want 0", {bus.Cout, bus.Ovf, bus.S});
      else pass_cnt++;
      bus.InValid = 1'b0;
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_carry_chain();
      int lat;
      send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
      total_cnt++;
      if (lat !== LAT) $display("FAIL t1_latency: got %0d want %0d", lat, LAT);
      else pass_cnt++;
      total_cnt++;
      if (bus.S !== 64'h0000_0000_0001_0000)
         $display("FAIL t1_sum: got %h want 0000000000010000", bus.S);
      else pass_cnt++;
      total_cnt++;
      if ({bus.Cout, bus.Ovf} !== 2'b00)
         $display("FAIL t1_flags: got %b want 00", {bus.Cout, bus.Ovf});
      else pass_cnt++;
      take_result();
      total_cnt++;
      if ({bus.InReady, bus.OutValid} !== 2'b10)
         $display("FAIL t1_release: got %b want 10", {bus.InReady, bus.OutValid});
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int lat;
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat);
      total_cnt++;
      if (lat !== LAT || bus.S !== 64'h0)
         $display("FAIL t2_sum: got lat %0d S %h want lat %0d S 0", lat, bus.S, LAT);
      else pass_cnt++;
      total_cnt++;
      if ({bus.Cout, bus.Ovf} !== 2'b10)
         $display("FAIL t2_flags: got %b want 10", {bus.Cout, bus.Ovf});
      else pass_cnt++;
      take_result();
   endtask

   task automatic test_overflow();
      int lat;
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
      total_cnt++;
      if (lat !== LAT || bus.S !== 64'h8000_0000_0000_0000)
         $display("FAIL t3_sum: got lat %0d S %h want lat %0d S 8000000000000000", lat, bus.S, LAT);
      else pass_cnt++;
      total_cnt++;
      if ({bus.Cout, bus.Ovf} !== 2'b01)
         $display("FAIL t3_flags: got %b want 01", {bus.Cout, bus.Ovf});
      else pass_cnt++;
      take_result();
   endtask

   task automatic test_subtract();
      int lat;
      send(64'd5, 64'd7, 1'b0, 1'b1, lat);
      total_cnt++;
      if (lat !== LAT || bus.S !== 64'hFFFF_FFFF_FFFF_FFFE)
         $display("FAIL t4_neg: got lat %0d S %h want lat %0d S fffffffffffffffe", lat, bus.S, LAT);
      else pass_cnt++;
      total_cnt++;
      if ({bus.Cout, bus.Ovf} !== 2'b00)
         $display("FAIL t4_neg_flags: got %b want 00", {bus.Cout, bus.Ovf});
      else pass_cnt++;
      take_result();
      send(64'd7, 64'd5, 1'b0, 1'b1, lat);
      total_cnt++;
      if (lat !== LAT || bus.S !== 64'd2)
         $display("FAIL t4_pos: got lat %0d S %h want lat %0d S 2", lat, bus.S, LAT);
      else pass_cnt++;
      total_cnt++;
      if ({bus.Cout, bus.Ovf} !== 2'b10)
         $display("FAIL t4_pos_flags: got %b want 10", {bus.Cout, bus.Ovf});
      else pass_cnt++;
      take_result();
   endtask

   // Result held under backpressure while a new request waits at the input.
   task automatic test_hold_done();
      int lat;
      int bad;
      send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat);
      total_cnt++;
      if (lat !== LAT || bus.S !== 64'h2345_6789_ABCD_F001)
         $display("FAIL t5_sum: got lat %0d S %h want lat %0d S 23456789abcdf001", lat, bus.S, LAT);
      else pass_cnt++;
      bus.A = 64'd3; bus.B = 64'd4; bus.Cin = 1'b0; bus.Sub = 1'b0; bus.InValid = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0 ||
             bus.S !== 64'h2345_6789_ABCD_F001) bad++;
      end
      total_cnt++;
      if (bad !== 0) $display("FAIL t5_hold: got %0d unstable cycles want 0", bad);
      else pass_cnt++;
      take_result();
      total_cnt++;
      if ({bus.InReady, bus.OutValid} !== 2'b10)
         $display("FAIL t5_release: got %b want 10", {bus.InReady, bus.OutValid});
      else pass_cnt++;
      send(64'd3, 64'd4, 1'b0, 1'b0, lat);
      total_cnt++;
      if (lat !== LAT || bus.S !== 64'd7)
         $display("FAIL t5_queued: got lat %0d S %h want lat %0d S 7", lat, bus.S, LAT);
      else pass_cnt++;
      take_result();
   endtask

   task automatic test_reset_mid_busy();
      int lat;
      int seen;
      bus.A = 64'hAAAA_AAAA_AAAA_AAAA; bus.B = 64'h5555_5555_5555_5555;
      bus.Cin = 1'b1; bus.Sub = 1'b0; bus.InValid = 1'b1;
      @(negedge Clk);
      bus.InValid = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      total_cnt++;
      if ({bus.InReady, bus.OutValid} !== 2'b10)
         $display("FAIL t6_abort: got %b want 10", {bus.InReady, bus.OutValid});
      else pass_cnt++;
      seen = 0;
      repeat (8) begin
         @(negedge Clk);
         if (bus.OutValid !== 1'b0) seen++;
      end
      total_cnt++;
      if (seen !== 0) $display("FAIL t6_no_valid: got %0d valid cycles want 0", seen);
      else pass_cnt++;
      send(64'hFFFF_FFFF_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
      total_cnt++;
      if (lat !== LAT || {bus.Cout, bus.Ovf, bus.S} !== {2'b00, 64'hFFFF_FFFF_0001_0000})
         $display("FAIL t6_fresh: got lat %0d %h want lat %0d %h", lat,
                  {bus.Cout, bus.Ovf, bus.S}, LAT, {2'b00, 64'hFFFF_FFFF_0001_0000});
      else pass_cnt++;
      take_result();
   endtask

   task automatic test_random_ref();
      int          lat;
      logic [63:0] a, b, bp;
      logic        cin, sub, ovf;
      logic [64:0] r;
      for (int n = 0; n < 200; n++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         cin = 1'($urandom);
         sub = 1'($urandom);
         bp  = b ^ {64{sub}};
         r   = {1'b0, a} + {1'b0, bp} + 65'(cin ^ sub);
         ovf = (a[63] == bp[63]) && (r[63] != a[63]);
         repeat ($urandom_range(0, 2)) @(negedge Clk);
         send(a, b, cin, sub, lat);
         repeat ($urandom_range(0, 2)) @(negedge Clk);
         total_cnt++;
         if (lat !== LAT || {bus.Cout, bus.Ovf, bus.S} !== {r[64], ovf, r[63:0]})
            $display("FAIL rand_%0d: got lat %0d %h want lat %0d %h", n, lat,
                     {bus.Cout, bus.Ovf, bus.S}, LAT, {r[64], ovf, r[63:0]});
         else pass_cnt++;
         take_result();
      end
   endtask

   initial begin
      Reset = 1'b1;
      bus.InValid = 1'b0; bus.A = '0; bus.B = '0;
      bus.Cin = 1'b0; bus.Sub = 1'b0; bus.OutReady = 1'b0;
      @(negedge Clk);
      test_reset();
      test_carry_chain();
      test_wrap();
      test_overflow();
      test_subtract();
      test_hold_done();
      test_reset_mid_busy();
      test_random_ref();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
